// File: rtl/buffer_5_bit_skid_pkg.sv
// Shared widths and state encoding for the 5-bit skid buffer and its DLX neighbours.
package buffer_5_bit_skid_pkg;

   localparam int unsigned DLX_REG_W = 5;
   localparam int unsigned WIDTH     = DLX_REG_W;
   localparam int unsigned COUNT_W   = 2;

   // State value doubles as the occupancy count.
   typedef enum logic [COUNT_W-1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/buffer_5_bit_skid_if.sv
// One valid/ready channel carrying a WIDTH-bit word.
interface buffer_5_bit_skid_if;
   import buffer_5_bit_skid_pkg::*;

   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/buffer_5_bit_skid.sv
// Two-entry registered skid buffer: every output comes straight from a flop,
// so neither ready nor data has a combinational path across the block.
module buffer_5_bit_skid
   import buffer_5_bit_skid_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   buffer_5_bit_skid_if.slave     up,
   buffer_5_bit_skid_if.master    dn,
   output logic [COUNT_W-1:0]     count
);

   state_e           state_q, state_nxt;
   logic [WIDTH-1:0] m_q, m_nxt;
   logic [WIDTH-1:0] s_q, s_nxt;
   logic             in_ready_q, in_ready_nxt;
   logic             out_valid_q, out_valid_nxt;
   logic             accept;
   logic             emit;

   // State and storage registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_EMPTY;
         m_q         <= '0;
         s_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         m_q         <= m_nxt;
         s_q         <= s_nxt;
         in_ready_q  <= in_ready_nxt;
         out_valid_q <= out_valid_nxt;
      end
   end

   // Next-state, storage update and next-cycle handshake outputs.
   always_comb begin
      state_nxt = state_q;
      m_nxt     = m_q;
      s_nxt     = s_q;
      accept    = up.valid & in_ready_q;
      emit      = out_valid_q & dn.ready;

      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  m_nxt     = up.data;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  m_nxt = up.data;
               end else if (accept) begin
                  s_nxt     = up.data;
                  state_nxt = ST_FULL;
               end else if (emit) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (emit) begin
                  m_nxt     = s_q;
                  state_nxt = ST_ONE;
               end
            end
            // Unused encoding falls back to empty.
            default: state_nxt = ST_EMPTY;
         endcase
      end

      in_ready_nxt  = (state_nxt != ST_FULL);
      out_valid_nxt = (state_nxt != ST_EMPTY);
   end

   assign up.ready = in_ready_q;
   assign dn.data  = m_q;
   assign dn.valid = out_valid_q;
   assign count    = state_q;

endmodule

// File: tb/tb_buffer_5_bit_skid.sv
// Directed and scoreboarded checks for the 5-bit skid buffer.
module tb_buffer_5_bit_skid;
   import buffer_5_bit_skid_pkg::*;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               flush = 1'b0;
   logic [COUNT_W-1:0] count;
   int                 n_checks = 0;
   int                 n_fail = 0;

   buffer_5_bit_skid_if up_if ();
   buffer_5_bit_skid_if dn_if ();

   buffer_5_bit_skid dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .up      (up_if.slave),
      .dn      (dn_if.master),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
      up_if.valid = v;
      up_if.data  = d;
      dn_if.ready = r;
   endtask

   logic [WIDTH-1:0] mq[$];
   logic             pv;
   logic [WIDTH-1:0] pd;
   logic             rr;
   logic             fl;
   logic             acc;
   logic             emt;

   initial begin
      drive(1'b1, 5'h1F, 1'b0);

      // Reset held with a word offered.
      repeat (3) step();
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(dn_if.valid), 32'd0);
      check("rst_in_ready", 32'(up_if.ready), 32'd1);
      check("rst_out_data", 32'(dn_if.data), 32'h00);
      reset_n = 1'b1;
      step();
      check("post_rst_valid", 32'(dn_if.valid), 32'd1);
      check("post_rst_data", 32'(dn_if.data), 32'h1F);
      drive(1'b0, 5'h00, 1'b1);
      step();
      check("drain_count", 32'(count), 32'd0);

      // Streaming at full rate.
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, WIDTH'(i), 1'b1);
         step();
         check("stream_data", 32'(dn_if.data), 32'(i));
         check("stream_valid", 32'(dn_if.valid), 32'd1);
         check("stream_in_ready", 32'(up_if.ready), 32'd1);
      end
      drive(1'b0, 5'h00, 1'b1);
      step();
      check("stream_end_count", 32'(count), 32'd0);

      // Backpressure fills the skid slot.
      drive(1'b1, 5'h0A, 1'b0);
      step();
      check("bp_count1", 32'(count), 32'd1);
      drive(1'b1, 5'h15, 1'b0);
      step();
      check("bp_count2", 32'(count), 32'd2);
      check("bp_in_ready", 32'(up_if.ready), 32'd0);
      drive(1'b1, 5'h03, 1'b0);
      step();
      check("bp_hold_count", 32'(count), 32'd2);
      check("bp_hold_data", 32'(dn_if.data), 32'h0A);
      dn_if.ready = 1'b1;
      step();
      check("bp_out2", 32'(dn_if.data), 32'h15);
      check("bp_out2_count", 32'(count), 32'd1);
      step();
      check("bp_out3", 32'(dn_if.data), 32'h03);
      check("bp_out3_count", 32'(count), 32'd1);
      drive(1'b0, 5'h00, 1'b1);
      step();
      check("bp_empty", 32'(count), 32'd0);

      // Accept and emit together in ONE.
      drive(1'b1, 5'h07, 1'b0);
      step();
      check("sim_pre_data", 32'(dn_if.data), 32'h07);
      drive(1'b1, 5'h08, 1'b1);
      step();
      check("sim_count", 32'(count), 32'd1);
      check("sim_data", 32'(dn_if.data), 32'h08);
      drive(1'b0, 5'h00, 1'b1);
      step();

      // Flush from FULL while offering and consuming.
      drive(1'b1, 5'h01, 1'b0);
      step();
      drive(1'b1, 5'h02, 1'b0);
      step();
      check("fl_pre_count", 32'(count), 32'd2);
      flush = 1'b1;
      drive(1'b1, 5'h11, 1'b1);
      step();
      flush = 1'b0;
      check("fl_count", 32'(count), 32'd0);
      check("fl_out_valid", 32'(dn_if.valid), 32'd0);
      check("fl_in_ready", 32'(up_if.ready), 32'd1);
      drive(1'b0, 5'h00, 1'b1);
      repeat (3) begin
         step();
         check("fl_no_11", 32'(dn_if.valid), 32'd0);
      end

      // Flush from ONE discards a simultaneous accept.
      drive(1'b1, 5'h04, 1'b0);
      step();
      flush = 1'b1;
      drive(1'b1, 5'h11, 1'b0);
      step();
      flush = 1'b0;
      check("fl1_count", 32'(count), 32'd0);
      drive(1'b0, 5'h00, 1'b1);

      // Asynchronous reset between edges.
      drive(1'b1, 5'h09, 1'b0);
      step();
      drive(1'b1, 5'h0C, 1'b0);
      step();
      check("ar_pre_count", 32'(count), 32'd2);
      #2 reset_n = 1'b0;
      #1;
      check("ar_count", 32'(count), 32'd0);
      check("ar_out_valid", 32'(dn_if.valid), 32'd0);
      check("ar_in_ready", 32'(up_if.ready), 32'd1);
      check("ar_out_data", 32'(dn_if.data), 32'h00);
      drive(1'b0, 5'h00, 1'b0);
      step();
      reset_n = 1'b1;

      // Random traffic against a queue model; stalled producers hold their word.
      pv = 1'b0;
      pd = '0;
      for (int c = 0; c < 10000; c++) begin
         if (!pv) begin
            pv = ($urandom_range(0, 3) != 0);
            pd = WIDTH'($urandom);
         end
         rr = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 127) == 0);
         drive(pv, pd, rr);
         flush = fl;
         check("rnd_count", 32'(count), 32'(mq.size()));
         check("rnd_valid", 32'(dn_if.valid), 32'(mq.size() != 0));
         check("rnd_in_ready", 32'(up_if.ready), 32'(mq.size() < 2));
         if (mq.size() != 0) check("rnd_data", 32'(dn_if.data), 32'(mq[0]));
         acc = pv && (mq.size() < 2);
         emt = rr && (mq.size() != 0);
         step();
         if (fl) begin
            mq.delete();
         end else begin
            if (emt) void'(mq.pop_front());
            if (acc) mq.push_back(pd);
         end
         if (acc) pv = 1'b0;
      end
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/buffer_5_bit_skid.md
Name: buffer_5_bit_skid

Overview:
- Registered receiving end of a 5-bit point-to-point channel with a valid/ready handshake, e.g. register-file indices or packed pixel-control fields in the DLX sharpening datapath.
- Replaces the pass-through buffering wherever the producer and consumer must be decoupled by a clock edge.
- Two-entry skid storage, so IN_READY is a pure register output and full throughput is sustained with no combinational ready path.

Parameters:
- WIDTH, 5, data width in bits; the block is verified only at 5. No other values are supported.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear of all stored entries; takes priority over every transfer.
- IN_DATA  in  WIDTH  upstream data.
- IN_VALID  in  1  upstream data valid.
- IN_READY  out  1  block can accept; driven directly from a flop.
- OUT_DATA  out  WIDTH  head entry; driven from a flop, no combinational path from IN_DATA.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream accepts.
- COUNT  out  2  occupancy, 0 to 2.

Behaviour:
- Accept = IN_VALID & IN_READY. Emit = OUT_VALID & OUT_READY. Both are evaluated on the same edge.
- Storage: main register M (drives OUT_DATA) and skid register S.
- States are EMPTY, ONE and FULL, encoded as COUNT = 0, 1, 2.
- Reset (RESET_N=0, takes effect immediately):
  - state EMPTY, COUNT=0, OUT_VALID=0, IN_READY=1, OUT_DATA=0, M=S=0.
  - Reset mid-transfer discards all data; no partial handshake completes.
- Outputs:
  - IN_READY = (state != FULL), registered.
  - OUT_VALID = (state != EMPTY).
- Transitions, evaluated only when FLUSH=0:
  - EMPTY + accept: M<=IN_DATA, go to ONE. Latency IN to OUT is 1 cycle.
  - ONE + accept + emit: M<=IN_DATA, stay in ONE. This is full throughput, 1 word per cycle.
  - ONE + accept, no emit: S<=IN_DATA, go to FULL. IN_READY falls on the next cycle.
  - ONE + emit, no accept: go to EMPTY. M keeps its stale value, but OUT_VALID=0.
  - FULL + emit: M<=S, go to ONE. IN_READY rises on the next cycle.
  - FULL + IN_VALID: no accept, because IN_READY=0. IN_DATA is ignored and the producer must hold it.
  - No event in any state: hold.
- Ordering: strict FIFO. Words leave in acceptance order; none are lost or duplicated.
- FLUSH=1 at an edge:
  - state EMPTY, COUNT=0, IN_READY=1 next cycle.
  - Any accept or emit on that edge is discarded. The bench must not count it as transferred.
- Consumer rule: OUT_DATA and OUT_VALID stay stable while OUT_VALID=1 and OUT_READY=0 (AXI-style hold).
- The block never checks that the producer holds IN_DATA while stalled.
- Width rule: no arithmetic on data. COUNT is saturating by construction and never exceeds 2.
- Illegal state encodings (COUNT=3) recover to EMPTY on the next edge.

Decomposition:
- Shared package holds:
  - the state localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - DLX_REG_W=5, shared with the register-file and decode blocks.
- No sub-module. The block is a single FSM plus two WIDTH-bit registers; splitting it adds nothing.

Test Plan:
- Reset: hold RESET_N=0 with IN_VALID=1 and IN_DATA=5'h1F. Required: COUNT=0, OUT_VALID=0, IN_READY=1, OUT_DATA=0. Release reset, then after 1 edge: OUT_VALID=1, OUT_DATA=5'h1F.
- Streaming: OUT_READY=1, drive 5'h00 to 5'h1F on consecutive cycles. Required: each value appears on OUT_DATA exactly 1 cycle later, in order, with no bubbles and IN_READY held at 1.
- Backpressure/skid: OUT_READY=0, push 5'h0A then 5'h15. Required: COUNT=2 and IN_READY=0. A third value 5'h03 held on IN_DATA is not taken. Raise OUT_READY and the outputs are 0A, 15, 03 in order.
- Simultaneous accept and emit in ONE: COUNT=1 holding 5'h07, IN_VALID=1 with 5'h08, OUT_READY=1. Required: COUNT stays 1, OUT_DATA=5'h08 next cycle.
- Flush: COUNT=2, then assert FLUSH together with IN_VALID=1 (5'h11) and OUT_READY=1. Required next cycle: COUNT=0, OUT_VALID=0, IN_READY=1. 5'h11 never appears on OUT_DATA.
- Async reset mid-operation: COUNT=2, assert RESET_N=0 between edges. Required: immediately COUNT=0, OUT_VALID=0, IN_READY=1. A random valid/ready scoreboard run of 10k cycles passes afterwards.
